// File: rtl/mem_bus_if.sv
// mem_bus_if
// Memory-side bus interface sitting directly behind the CPU datapath system bus.
// A transfer request is latched from the 16-bit system bus, then chip-select,
// output-enable and write-enable strobes are sequenced towards an asynchronous
// SRAM/peripheral with a programmable number of wait states. Read data is handed
// back to the datapath together with a one-cycle Ready pulse; a missing
// acknowledge turns into a Ready+BusErr pulse.
//
// Parameters:
//   WAIT_CYCLES  extra ACCESS cycles before MemAck is looked at (0..15)
//   TIMEOUT      further ACCESS cycles tolerated without MemAck (1..255)
//
// Ports:
//   Clock, nReset          system clock, synchronous active-low reset
//   Req, Write             transfer request and direction (1=write), taken in IDLE
//   AddrIn, WrData         address / write data from the system bus
//   RdData                 read data to the datapath, held until the next read ends
//   Ready, BusErr          end-of-transfer pulse, error qualifier
//   Busy                   high whenever a transfer is in progress
//   MemAddr, MemWData      latched address / write data towards memory
//   MemRData, MemAck       read data and acknowledge from memory
//   nMemCS, nMemOE, nMemWE active-low memory strobes
module mem_bus_if #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        Req,
    input  logic        Write,
    input  logic [15:0] AddrIn,
    input  logic [15:0] WrData,
    output logic [15:0] RdData,
    output logic        Ready,
    output logic        Busy,
    output logic        BusErr,
    output logic [15:0] MemAddr,
    output logic [15:0] MemWData,
    input  logic [15:0] MemRData,
    input  logic        MemAck,
    output logic        nMemCS,
    output logic        nMemOE,
    output logic        nMemWE
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        write_q, write_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        cs_n_q, cs_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;

    // Next-state logic and transfer bookkeeping. The timeout counter only
    // advances once the wait states are spent; the limit is checked before
    // incrementing, so the counter never needs to wrap or saturate explicitly.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                if (Req) begin
                    addr_d     = AddrIn;
                    wdata_d    = WrData;
                    write_d    = Write;
                    wait_cnt_d = WAIT_INIT;
                    tmo_cnt_d  = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else if (MemAck) begin
                    if (!write_q) begin
                        rdata_d = MemRData;
                    end
                    state_d = DONE;
                end else if (tmo_cnt_q >= TMO_LIMIT) begin
                    if (!write_q) begin
                        rdata_d = 16'hFFFF;
                    end
                    state_d = ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            DONE, ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs are registered: they are decoded from the state being entered
    // so that each flop shows the value belonging to that state. Strobe decode
    // keeps OE and WE mutually exclusive and only ever low under CS.
    always_comb begin
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == DONE) || (state_d == ERR);
        err_d   = (state_d == ERR);
        cs_n_d  = !((state_d == SETUP) || (state_d == ACCESS));
        oe_n_d  = !((state_d == ACCESS) && !write_d);
        we_n_d  = !((state_d == ACCESS) && write_d);
    end

    // State and output registers. A reset that lands mid-transfer aborts it
    // without touching RdData, so the datapath still sees the last good read;
    // only a reset from IDLE clears RdData.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            if (state_q == IDLE) begin
                rdata_q <= '0;
            end
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            cs_n_q     <= cs_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
        end
    end

    assign RdData   = rdata_q;
    assign Ready    = ready_q;
    assign Busy     = busy_q;
    assign BusErr   = err_q;
    assign MemAddr  = addr_q;
    assign MemWData = wdata_q;
    assign nMemCS   = cs_n_q;
    assign nMemOE   = oe_n_q;
    assign nMemWE   = we_n_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if
// Self-checking bench for mem_bus_if. A transaction-level model predicts every
// output from the transfer length (setup + wait states + acknowledge delay) and
// a compare process checks the DUT against it each cycle; directed transfers
// pin latencies and data with literal values before a randomized run.
module tb_mem_bus_if;

    localparam int WAIT_CYCLES = 1;
    localparam int TIMEOUT     = 15;

    logic        Clock;
    logic        nReset;
    logic        Req;
    logic        Write;
    logic [15:0] AddrIn;
    logic [15:0] WrData;
    logic [15:0] RdData;
    logic        Ready;
    logic        Busy;
    logic        BusErr;
    logic [15:0] MemAddr;
    logic [15:0] MemWData;
    logic [15:0] MemRData;
    logic        MemAck;
    logic        nMemCS;
    logic        nMemOE;
    logic        nMemWE;

    mem_bus_if #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .Clock   (Clock),
        .nReset  (nReset),
        .Req     (Req),
        .Write   (Write),
        .AddrIn  (AddrIn),
        .WrData  (WrData),
        .RdData  (RdData),
        .Ready   (Ready),
        .Busy    (Busy),
        .BusErr  (BusErr),
        .MemAddr (MemAddr),
        .MemWData(MemWData),
        .MemRData(MemRData),
        .MemAck  (MemAck),
        .nMemCS  (nMemCS),
        .nMemOE  (nMemOE),
        .nMemWE  (nMemWE)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: m_n is the cycle number inside the current
    // transfer (1 = setup, 2..m_len+1 = access, m_len+2 = completion).
    bit          m_active;
    int          m_n;
    int          m_len;
    int          m_k;
    bit          m_err;
    bit          m_write;
    logic [15:0] exp_rd;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    int          pend_k;
    bit          check_en;

    // Access length: wait states, one cycle where MemAck is first looked at,
    // then one extra cycle per missing acknowledge up to the timeout limit.
    function automatic int accessLen(input int k);
        return WAIT_CYCLES + 1 + ((k < TIMEOUT) ? k : TIMEOUT);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic modelStep();
        if (!nReset) begin
            if (!m_active) exp_rd = 16'h0000;
            m_active  = 1'b0;
            m_n       = 0;
            exp_addr  = 16'h0000;
            exp_wdata = 16'h0000;
        end else if (m_active) begin
            m_n++;
            if (m_n == m_len + 2) begin
                if (!m_write) exp_rd = m_err ? 16'hFFFF : MemRData;
            end else if (m_n > m_len + 2) begin
                m_active = 1'b0;
                m_n      = 0;
            end
        end else if (Req) begin
            m_active  = 1'b1;
            m_n       = 1;
            m_write   = Write;
            exp_addr  = AddrIn;
            exp_wdata = WrData;
            m_k       = pend_k;
            m_len     = accessLen(m_k);
            m_err     = (m_k > TIMEOUT);
        end
    endtask

    // MemAck follows the chosen acknowledge delay once wait states are spent;
    // everywhere else it is random noise the DUT must ignore.
    task automatic driveAck();
        if (m_active && m_n >= 2 && m_n <= m_len + 1 && (m_n - 1) > WAIT_CYCLES)
            MemAck = ((m_n - 1) == WAIT_CYCLES + 1 + m_k);
        else
            MemAck = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
        modelStep();
        driveAck();
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge Clock) begin : compare
        logic ex_ready;
        logic ex_cs;
        logic ex_acc;
        if (check_en) begin
            ex_ready = m_active && (m_n == m_len + 2);
            ex_cs    = m_active && (m_n >= 1) && (m_n <= m_len + 1);
            ex_acc   = m_active && (m_n >= 2) && (m_n <= m_len + 1);
            checkOutput("busy",     16'(Busy),   16'(m_active));
            checkOutput("ready",    16'(Ready),  16'(ex_ready));
            checkOutput("buserr",   16'(BusErr), 16'(ex_ready && m_err));
            checkOutput("ncs",      16'(nMemCS), 16'(!ex_cs));
            checkOutput("noe",      16'(nMemOE), 16'(!(ex_acc && !m_write)));
            checkOutput("nwe",      16'(nMemWE), 16'(!(ex_acc && m_write)));
            checkOutput("rddata",   RdData,   exp_rd);
            checkOutput("memaddr",  MemAddr,  exp_addr);
            checkOutput("memwdata", MemWData, exp_wdata);
        end
    end

    task automatic waitIdle();
        int n;
        n = 0;
        Req = 1'b0;
        while (m_active && n < 50) begin
            tick();
            n++;
        end
        if (m_active) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_idle actual=busy expected=idle");
        end
    endtask

    // Runs one transfer from an IDLE cycle and returns in its completion cycle.
    task automatic applyStimulus(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] rdata, input int k, input bit pulse_req,
                                 output int lat, output int oe_low, output int we_low,
                                 output bit err_seen, output bit addr_ok);
        int c;
        bit got;
        lat = 0; oe_low = 0; we_low = 0; err_seen = 1'b0; addr_ok = 1'b1; got = 1'b0;
        Req = 1'b1; Write = wr; AddrIn = addr; WrData = wdata; MemRData = rdata; pend_k = k;
        tick();
        Req = 1'b0;
        c = 1;
        while (!got && c < 40) begin
            if (!nMemOE) oe_low++;
            if (!nMemWE) we_low++;
            if (!nMemCS && (MemAddr !== addr || MemWData !== wdata)) addr_ok = 1'b0;
            if (Ready) begin
                got = 1'b1;
                lat = c;
                err_seen = BusErr;
            end else begin
                if (pulse_req) begin
                    Req = (c == 2);
                    if (c == 2) AddrIn = 16'hDEAD;
                end
                tick();
                c++;
            end
        end
        Req = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL ready_timeout actual=no_ready expected=ready");
        end
    endtask

    initial begin
        int lat, oe_low, we_low, r;
        bit err_seen, addr_ok;
        logic [15:0] prev_rd;

        nReset = 1'b0; Req = 1'b0; Write = 1'b0; AddrIn = '0; WrData = '0;
        MemRData = '0; MemAck = 1'b0; pend_k = 0;
        m_active = 1'b0; m_n = 0; m_len = 0; m_k = 0; m_err = 1'b0; m_write = 1'b0;
        exp_rd = '0; exp_addr = '0; exp_wdata = '0; check_en = 1'b0;

        tick();
        tick();
        check_en = 1'b1;
        checkOutput("reset_rddata", RdData, 16'h0000);
        checkOutput("reset_ncs", 16'(nMemCS), 16'h0001);
        checkOutput("reset_busy", 16'(Busy), 16'h0000);
        nReset = 1'b1;
        tick();

        // Plain read, acknowledge immediately available.
        waitIdle();
        applyStimulus(1'b0, 16'h0123, 16'h0000, 16'hBEEF, 0, 1'b0, lat, oe_low, we_low, err_seen, addr_ok);
        checkOutput("t1_latency", 16'(lat), 16'd4);
        checkOutput("t1_oe_low", 16'(oe_low), 16'd2);
        checkOutput("t1_rddata", RdData, 16'hBEEF);
        checkOutput("t1_buserr", 16'(err_seen), 16'd0);

        // Write: WE low for two cycles with stable address/data, OE untouched.
        waitIdle();
        applyStimulus(1'b1, 16'h0040, 16'h5A5A, 16'h1111, 0, 1'b0, lat, oe_low, we_low, err_seen, addr_ok);
        checkOutput("t2_latency", 16'(lat), 16'd4);
        checkOutput("t2_we_low", 16'(we_low), 16'd2);
        checkOutput("t2_oe_low", 16'(oe_low), 16'd0);
        checkOutput("t2_addr_stable", 16'(addr_ok), 16'd1);
        checkOutput("t2_rddata_kept", RdData, 16'hBEEF);

        // Read with three missing acknowledges.
        waitIdle();
        applyStimulus(1'b0, 16'h0200, 16'h0000, 16'hC0DE, 3, 1'b0, lat, oe_low, we_low, err_seen, addr_ok);
        checkOutput("t3_latency", 16'(lat), 16'd7);
        checkOutput("t3_rddata", RdData, 16'hC0DE);

        // Read that never gets acknowledged.
        waitIdle();
        applyStimulus(1'b0, 16'h0300, 16'h0000, 16'h2222, TIMEOUT + 5, 1'b0, lat, oe_low, we_low, err_seen, addr_ok);
        checkOutput("t4_latency", 16'(lat), 16'd19);
        checkOutput("t4_buserr", 16'(err_seen), 16'd1);
        checkOutput("t4_rddata", RdData, 16'hFFFF);
        checkOutput("t4_ncs", 16'(nMemCS), 16'd1);

        // Req pulsed during ACCESS is dropped; Req held from the completion
        // cycle is taken in the following IDLE cycle.
        waitIdle();
        applyStimulus(1'b0, 16'h0400, 16'h0000, 16'h3333, 0, 1'b1, lat, oe_low, we_low, err_seen, addr_ok);
        checkOutput("t5_latency", 16'(lat), 16'd4);
        checkOutput("t5_addr_not_requeued", 16'(addr_ok), 16'd1);
        Req = 1'b1; Write = 1'b1; AddrIn = 16'h0500; WrData = 16'h7777; pend_k = 0;
        tick();
        checkOutput("t5_idle_gap", 16'(Busy), 16'd0);
        checkOutput("t5_no_second_ready", 16'(Ready), 16'd0);
        tick();
        Req = 1'b0;
        checkOutput("t5_b2b_busy", 16'(Busy), 16'd1);
        checkOutput("t5_b2b_addr", MemAddr, 16'h0500);

        // Reset in the middle of a write.
        waitIdle();
        prev_rd = RdData;
        Req = 1'b1; Write = 1'b1; AddrIn = 16'h1234; WrData = 16'h4321; pend_k = 0;
        tick();
        Req = 1'b0;
        tick();
        checkOutput("t6_we_active", 16'(nMemWE), 16'd0);
        nReset = 1'b0;
        tick();
        checkOutput("t6_nwe", 16'(nMemWE), 16'd1);
        checkOutput("t6_ncs", 16'(nMemCS), 16'd1);
        checkOutput("t6_busy", 16'(Busy), 16'd0);
        checkOutput("t6_ready", 16'(Ready), 16'd0);
        checkOutput("t6_rddata", RdData, prev_rd);
        nReset = 1'b1;
        tick();

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 2000; i++) begin
            nReset   = ($urandom_range(0, 79) != 0);
            Req      = ($urandom_range(0, 2) == 0);
            Write    = 1'($urandom_range(0, 1));
            AddrIn   = 16'($urandom);
            WrData   = 16'($urandom);
            MemRData = 16'($urandom);
            r = $urandom_range(0, 9);
            if (r < 6)       pend_k = $urandom_range(0, 4);
            else if (r == 6) pend_k = TIMEOUT - 1;
            else if (r == 7) pend_k = TIMEOUT;
            else             pend_k = TIMEOUT + 1 + $urandom_range(0, 3);
            tick();
        end

        nReset = 1'b1;
        waitIdle();
        tick();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
